i2s_rx: RTL and testbench

I2S serial-to-parallel receiver for the 12.288 MHz audio domain. It samples an external I2S stream (SCLK, LRCLK, SD) with the system clock, recovers left and right words MSB-first with the standard one-bit delay, and presents each complete stereo frame as parallel words with a one-cycle `o_finish` strobe. The block is the capture counterpart of the I2S transmit path, and its outputs connect directly to the transmitter's `i_audio_l`, `i_audio_r` and `i_finish` inputs for loopback.

---
 rtl/i2s_rx_if.sv | 29 ++
 rtl/i2s_rx.sv | 151 +++++++++++++++
 tb/tb_i2s_rx.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_rx_if.sv
// I2S receive bundle: serial pins in, recovered stereo frame out.
//
// Handshake: o_finish is a valid-only strobe with no ready. It is high for
// exactly one i_clk_12_288 cycle when o_audio_l/o_audio_r take a new frame.
// The sink must capture on that cycle. The words then stay stable until the
// next o_finish. o_err is a separate one-cycle strobe with no payload.
interface i2s_rx_if #(
  parameter int DATA_BIT = 24
);
  logic                i_sclk;
  logic                i_lrclk;
  logic                i_sd;
  logic [DATA_BIT-1:0] o_audio_l;
  logic [DATA_BIT-1:0] o_audio_r;
  logic                o_finish;
  logic                o_err;

  // Source of the serial stream (pins) and consumer of the frames.
  modport master (
    output i_sclk, i_lrclk, i_sd,
    input  o_audio_l, o_audio_r, o_finish, o_err
  );

  // The receiver itself.
  modport slave (
    input  i_sclk, i_lrclk, i_sd,
    output o_audio_l, o_audio_r, o_finish, o_err
  );
endinterface

// File: rtl/i2s_rx.sv
// I2S serial-to-parallel receiver in the 12.288 MHz domain.
// SCLK, LRCLK and SD are oversampled through 2-FF synchronisers. Bits are
// captured MSB-first on each detected SCLK rise. The LRCLK change edge
// carries the last bit of the outgoing slot (standard one-bit delay).
// A stereo frame is emitted on the right-to-left change edge.
module i2s_rx #(
  parameter int DATA_BIT = 24
) (
  input  logic       i_clk_12_288,
  input  logic       i_reset,
  i2s_rx_if.slave    bus,
  output logic [1:0] o_state
);

  localparam int CW = $clog2(DATA_BIT + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_BIT - 1);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [1:0]          sclk_sync, lrclk_sync, sd_sync;
  logic                sclk_d;
  logic                ws_prev;
  logic [CW-1:0]       cnt;
  logic [DATA_BIT-1:0] shreg;
  logic                left_ok, left_ok_nxt;
  logic [DATA_BIT-1:0] left_hold;

  logic                rise, ws, sd_bit, change;
  logic                slot_done;
  logic [DATA_BIT-1:0] word_shift, word_done;
  logic                hold_left, emit, err_nxt;

  // Bring the asynchronous I2S pins into the system clock domain.
  always_ff @(posedge i_clk_12_288 or posedge i_reset) begin
    if (i_reset) begin
      sclk_sync  <= '0;
      lrclk_sync <= '0;
      sd_sync    <= '0;
      sclk_d     <= 1'b0;
    end else begin
      sclk_sync  <= {sclk_sync[0], bus.i_sclk};
      lrclk_sync <= {lrclk_sync[0], bus.i_lrclk};
      sd_sync    <= {sd_sync[0], bus.i_sd};
      sclk_d     <= sclk_sync[1];
    end
  end

  // Decode SCLK rise, LRCLK change and the word that ends on a change.
  always_comb begin
    rise       = sclk_sync[1] & ~sclk_d;
    ws         = lrclk_sync[1];
    sd_bit     = sd_sync[1];
    change     = rise & (ws != ws_prev);
    word_shift = {shreg[DATA_BIT-2:0], sd_bit};
    // Exact-fit slot takes the change-edge bit; an overlong slot drops it.
    slot_done  = (cnt == CNT_LAST) | (cnt == CNT_FULL);
    word_done  = (cnt == CNT_FULL) ? shreg : word_shift;
  end

  // Shift register, saturating bit counter and previous word select.
  always_ff @(posedge i_clk_12_288 or posedge i_reset) begin
    if (i_reset) begin
      cnt     <= '0;
      shreg   <= '0;
      ws_prev <= 1'b0;
    end else if (rise) begin
      if (change) begin
        cnt     <= '0;
        shreg   <= '0;
        ws_prev <= ws;
      end else if (cnt < CNT_FULL) begin
        shreg <= word_shift;
        cnt   <= cnt + 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk_12_288 or posedge i_reset) begin
    if (i_reset) state <= SYNC;
    else         state <= state_nxt;
  end

  // Next state and frame/error decisions, all taken on a change rise.
  always_comb begin
    state_nxt   = state;
    left_ok_nxt = left_ok;
    hold_left   = 1'b0;
    emit        = 1'b0;
    err_nxt     = 1'b0;
    if (change) begin
      case (state)
        SYNC: begin
          if (!ws) state_nxt = LEFT;
        end
        LEFT: begin
          if (ws) begin
            state_nxt = RIGHT;
            if (slot_done) begin
              hold_left   = 1'b1;
              left_ok_nxt = 1'b1;
            end else begin
              err_nxt     = 1'b1;
              left_ok_nxt = 1'b0;
            end
          end
        end
        RIGHT: begin
          if (!ws) begin
            state_nxt   = LEFT;
            left_ok_nxt = 1'b0;
            if (!slot_done)   err_nxt = 1'b1;
            else if (left_ok) emit    = 1'b1;
          end
        end
        default: state_nxt = SYNC;
      endcase
    end
  end

  // Left word holding, frame outputs and one-cycle strobes.
  always_ff @(posedge i_clk_12_288 or posedge i_reset) begin
    if (i_reset) begin
      left_ok       <= 1'b0;
      left_hold     <= '0;
      bus.o_audio_l <= '0;
      bus.o_audio_r <= '0;
      bus.o_finish  <= 1'b0;
      bus.o_err     <= 1'b0;
    end else begin
      left_ok      <= left_ok_nxt;
      bus.o_finish <= emit;
      bus.o_err    <= err_nxt;
      if (hold_left) left_hold <= word_done;
      if (emit) begin
        bus.o_audio_l <= left_hold;
        bus.o_audio_r <= word_done;
      end
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: builds bit-level I2S streams, plays them at SCLK = clk/4
// and checks recovered frames against an expected queue.
module tb_i2s_rx;
  localparam int DW = 24;
  localparam int NMAX = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         cyc = 0;

  i2s_rx_if #(.DATA_BIT(DW)) bus();

  i2s_rx #(.DATA_BIT(DW)) dut (
    .i_clk_12_288 (clk),
    .i_reset      (rst),
    .bus          (bus),
    .o_state      (dbg_state)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_fail = 0;
  int          finish_cnt = 0;
  int          err_cnt = 0;
  int          err_base = 0;
  int          last_chg_cyc = 0;
  logic [47:0] exp_q[$];
  logic [47:0] exp_frame;

  logic ws_a[0:NMAX-1];
  logic sd_a[0:NMAX-1];
  int   n_bits;
  logic prev_ws;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stream();
    n_bits = 0;
    for (int i = 0; i < NMAX; i++) begin
      ws_a[i] = 1'b0;
      sd_a[i] = 1'b0;
    end
  endtask

  // One slot of len SCLK periods. Data starts one period after the word
  // select edge, so the LSB of a full-length slot lands on the next edge.
  task automatic add_slot(input logic ws, input logic [DW-1:0] data, input int len);
    for (int i = 0; i < len; i++) ws_a[n_bits + i] = ws;
    for (int k = 0; k < len && k < DW; k++) sd_a[n_bits + 1 + k] = data[DW-1-k];
    n_bits += len;
  endtask

  task automatic drive_period(input int i);
    @(negedge clk);
    bus.i_sclk  = 1'b0;
    bus.i_lrclk = ws_a[i];
    bus.i_sd    = sd_a[i];
    @(negedge clk);
    @(negedge clk);
    bus.i_sclk = 1'b1;
    if (ws_a[i] !== prev_ws) last_chg_cyc = cyc;
    prev_ws = ws_a[i];
    @(negedge clk);
  endtask

  task automatic play(input int from, input int to);
    for (int i = from; i < to; i++) drive_period(i);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic end_test(input string name, input int err_exp);
    repeat (40) @(negedge clk);
    check({name, "_frames_left"}, 64'(exp_q.size()), 0);
    check({name, "_err_count"}, 64'(err_cnt - err_base), 64'(err_exp));
    exp_q.delete();
    err_base = err_cnt;
  endtask

  // Scoreboard: compare every emitted frame and time every strobe
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_finish) begin
        finish_cnt++;
        check("finish_latency", 64'(cyc - last_chg_cyc), 3);
        check("frame_pending", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_frame = exp_q.pop_front();
          check("audio_l", 64'(bus.o_audio_l), 64'(exp_frame[47:24]));
          check("audio_r", 64'(bus.o_audio_r), 64'(exp_frame[23:0]));
        end
      end
      if (bus.o_err) begin
        err_cnt++;
        check("err_latency", 64'(cyc - last_chg_cyc), 3);
      end
    end
  end

  initial begin
    bus.i_sclk  = 1'b0;
    bus.i_lrclk = 1'b0;
    bus.i_sd    = 1'b0;
    prev_ws     = 1'b0;

    // Reset values with pins toggling randomly
    rst = 1'b1;
    for (int r = 0; r < 4; r++) begin
      repeat (3) begin
        @(negedge clk);
        bus.i_sclk  = 1'($urandom_range(0, 1));
        bus.i_lrclk = 1'($urandom_range(0, 1));
        bus.i_sd    = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      check("rst_audio_l", 64'(bus.o_audio_l), 0);
      check("rst_audio_r", 64'(bus.o_audio_r), 0);
      check("rst_finish", 64'(bus.o_finish), 0);
      check("rst_err", 64'(bus.o_err), 0);
      check("rst_state", 64'(dbg_state), 0);
    end
    bus.i_sclk  = 1'b0;
    bus.i_lrclk = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    clear_stream();
    add_slot(1'b1, '0, 40);
    for (int i = 0; i < n_bits; i++) sd_a[i] = 1'($urandom_range(0, 1));
    prev_ws = 1'b1;
    play(0, n_bits);
    repeat (10) @(negedge clk);
    check("idle_finish_count", 64'(finish_cnt), 0);
    check("idle_err_count", 64'(err_cnt), 0);
    check("idle_state_sync", 64'(dbg_state), 0);

    // Nominal 32-bit slots
    do_reset();
    clear_stream();
    add_slot(1'b1, '0, 32);
    add_slot(1'b0, 24'hA5A5A5, 32);
    add_slot(1'b1, 24'h3C3C3C, 32);
    add_slot(1'b0, '0, 4);
    exp_q.push_back({24'hA5A5A5, 24'h3C3C3C});
    play(0, n_bits);
    end_test("nominal", 0);

    // Reset released in the middle of a right slot
    @(negedge clk);
    rst = 1'b1;
    clear_stream();
    add_slot(1'b1, 24'h123456, 32);
    add_slot(1'b0, 24'h111111, 32);
    add_slot(1'b1, 24'h222222, 32);
    add_slot(1'b0, '0, 4);
    exp_q.push_back({24'h111111, 24'h222222});
    play(0, 8);
    rst = 1'b0;
    play(8, n_bits);
    end_test("midstream", 0);

    // Exact-fit 24-bit slots
    do_reset();
    clear_stream();
    add_slot(1'b1, '0, 24);
    add_slot(1'b0, 24'h800001, 24);
    add_slot(1'b1, 24'h7FFFFE, 24);
    add_slot(1'b0, '0, 4);
    exp_q.push_back({24'h800001, 24'h7FFFFE});
    play(0, n_bits);
    end_test("exact_fit", 0);

    // Short left slot, then a good frame
    do_reset();
    clear_stream();
    add_slot(1'b1, '0, 32);
    add_slot(1'b0, 24'hFFFFFF, 10);
    add_slot(1'b1, 24'h0F0F0F, 32);
    add_slot(1'b0, 24'hAAAAAA, 32);
    add_slot(1'b1, 24'h555555, 32);
    add_slot(1'b0, '0, 4);
    exp_q.push_back({24'hAAAAAA, 24'h555555});
    play(0, n_bits);
    end_test("short_slot", 1);

    // Reset halfway through a right slot
    do_reset();
    clear_stream();
    add_slot(1'b1, '0, 32);
    add_slot(1'b0, 24'hCAFE12, 32);
    add_slot(1'b1, 24'h345678, 32);
    add_slot(1'b0, 24'h0BADF0, 32);
    add_slot(1'b1, 24'hDEAD01, 32);
    add_slot(1'b0, 24'h13579B, 32);
    add_slot(1'b1, 24'h2468AC, 32);
    add_slot(1'b0, '0, 4);
    exp_q.push_back({24'hCAFE12, 24'h345678});
    exp_q.push_back({24'h13579B, 24'h2468AC});
    play(0, 144);
    check("pre_reset_frames", 64'(exp_q.size()), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_audio_l", 64'(bus.o_audio_l), 0);
    check("midrst_audio_r", 64'(bus.o_audio_r), 0);
    check("midrst_finish", 64'(bus.o_finish), 0);
    check("midrst_state", 64'(dbg_state), 0);
    rst = 1'b0;
    play(144, n_bits);
    end_test("midframe_reset", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
